// File: rtl/cpu_pkg.sv
// Shared CPU types: load-type codes, writeback FSM
// encoding and the captured-instruction bundle.
package cpu_pkg;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4,
    LT_LWL = 3'd5,
    LT_LWR = 3'd6
  } load_type_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_DRAIN = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic        is_load;
    logic        is_mem;
    load_type_e  ltype;
    logic [1:0]  addr_low;
    logic [31:0] rt;
    logic [4:0]  dest;
    logic [31:0] result;
  } wb_entry_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment: extracts and extends the
// addressed byte/halfword, or merges for LWL/LWR.
module load_align
  import cpu_pkg::*;
(
  input  load_type_e  ltype,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] rt,
  output logic [31:0] value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Select addressed byte and halfword
  always_comb begin
    byte_v = rdata[8*off +: 8];
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend or merge by load type
  always_comb begin
    value = rdata;
    unique case (ltype)
      LT_LB:  value = {{24{byte_v[7]}}, byte_v};
      LT_LBU: value = {24'h0, byte_v};
      LT_LH:  value = {{16{half_v[15]}}, half_v};
      LT_LHU: value = {16'h0, half_v};
      LT_LWL: begin
        unique case (off)
          2'd0: value = {rdata[7:0], rt[23:0]};
          2'd1: value = {rdata[15:0], rt[15:0]};
          2'd2: value = {rdata[23:0], rt[7:0]};
          default: value = rdata;
        endcase
      end
      LT_LWR: begin
        unique case (off)
          2'd1: value = {rt[31:24], rdata[31:8]};
          2'd2: value = {rt[31:16], rdata[31:16]};
          2'd3: value = {rt[31:8], rdata[31:24]};
          default: value = rdata;
        endcase
      end
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: holds one instruction, waits for
// load/store response, then retires for one cycle.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mem_req,
  input  logic            in_is_load,
  input  logic [2:0]      in_load_type,
  input  logic [1:0]      in_addr_low,
  input  logic [31:0]     in_rt_value,
  input  logic [4:0]      in_dest,
  input  logic [31:0]     in_result,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  input  logic            data_ok,
  input  logic [31:0]     data_rdata,
  output logic            wb_valid,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic [PC_W-1:0] wb_pc
);

  wb_state_e       state_q, state_d;
  wb_entry_t       ent_q, ent_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            cap;
  logic            ready;
  logic [31:0]     ld_val;

  load_align u_align (
    .ltype (ent_q.ltype),
    .off   (ent_q.addr_low),
    .rdata (rdata_q),
    .rt    (ent_q.rt),
    .value (ld_val)
  );

  // Next state, capture and response latching
  always_comb begin
    state_d  = state_q;
    ent_d    = ent_q;
    pc_d     = pc_q;
    rdata_d  = rdata_q;
    in_ready = (state_q == S_EMPTY) ||
               (state_q == S_READY);
    cap      = in_valid & in_ready & ~flush;
    unique case (state_q)
      S_EMPTY, S_READY: begin
        if (cap)
          state_d = in_mem_req ? S_WAIT : S_READY;
        else
          state_d = S_EMPTY;
      end
      S_WAIT: begin
        if (flush) begin
          state_d = data_ok ? S_EMPTY : S_DRAIN;
        end else if (data_ok) begin
          state_d = S_READY;
          rdata_d = data_rdata;
        end
      end
      S_DRAIN: begin
        if (data_ok)
          state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
    if (cap) begin
      ent_d.is_load  = in_is_load;
      ent_d.is_mem   = in_mem_req;
      ent_d.ltype    = load_type_e'(in_load_type);
      ent_d.addr_low = in_addr_low;
      ent_d.rt       = in_rt_value;
      ent_d.dest     = in_dest;
      ent_d.result   = in_result;
      pc_d           = in_pc;
    end
  end

  // Retirement outputs, zero outside READY
  always_comb begin
    ready    = (state_q == S_READY);
    wb_valid = ready & ~flush;
    rf_wen   = ready & ~flush &
               (ent_q.is_load | ~ent_q.is_mem) &
               (ent_q.dest != 5'd0);
    rf_waddr = ready ? ent_q.dest : 5'd0;
    wb_pc    = ready ? pc_q : '0;
    rf_wdata = 32'h0;
    if (ready)
      rf_wdata = ent_q.is_load ? ld_val
                               : ent_q.result;
  end

  // State and captured-instruction registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_EMPTY;
      ent_q   <= '0;
      pc_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage.
// Each task drives a scenario and checks inline.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic        in_mem_req;
  logic        in_is_load;
  logic [2:0]  in_load_type;
  logic [1:0]  in_addr_low;
  logic [31:0] in_rt_value;
  logic [4:0]  in_dest;
  logic [31:0] in_result;
  logic [31:0] in_pc;
  logic        flush;
  logic        data_ok;
  logic [31:0] data_rdata;
  logic        wb_valid;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] wb_pc;

  int checks = 0;
  int errors = 0;

  writeback_stage #(.PC_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mem_req   (in_mem_req),
    .in_is_load   (in_is_load),
    .in_load_type (in_load_type),
    .in_addr_low  (in_addr_low),
    .in_rt_value  (in_rt_value),
    .in_dest      (in_dest),
    .in_result    (in_result),
    .in_pc        (in_pc),
    .flush        (flush),
    .data_ok      (data_ok),
    .data_rdata   (data_rdata),
    .wb_valid     (wb_valid),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .wb_pc        (wb_pc)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge
  task automatic issue(
    input logic        mem,
    input logic        ld,
    input logic [2:0]  lt,
    input logic [1:0]  n,
    input logic [31:0] rt,
    input logic [4:0]  d,
    input logic [31:0] res,
    input logic [31:0] pc
  );
    in_valid     = 1'b1;
    in_mem_req   = mem;
    in_is_load   = ld;
    in_load_type = lt;
    in_addr_low  = n;
    in_rt_value  = rt;
    in_dest      = d;
    in_result    = res;
    in_pc        = pc;
    tick;
    in_valid     = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wb_valid !== 1'b0 || rf_wen !== 1'b0 ||
        rf_waddr !== 5'd0 || rf_wdata !== 32'h0 ||
        wb_pc !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset v=%b w=%b a=%h d=%h pc=%h r=%b",
               wb_valid, rf_wen, rf_waddr, rf_wdata,
               wb_pc, in_ready);
    end
    resetn = 1'b1;
  endtask

  task automatic test_nonmem;
    issue(0, 0, 3'd0, 2'd0, 0, 5'd5, 32'h1234, 32'h100);
    checks++;
    if (wb_valid !== 1'b1 || rf_wen !== 1'b1 ||
        rf_wdata !== 32'h1234 || rf_waddr !== 5'd5 ||
        wb_pc !== 32'h100) begin
      errors++;
      $display("FAIL nonmem v=%b w=%b d=%h a=%h pc=%h exp 1 1 1234 05 100",
               wb_valid, rf_wen, rf_wdata, rf_waddr, wb_pc);
    end
    data_ok = 1'b1;
    data_rdata = 32'hFFFF_FFFF;
    tick;
    data_ok = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL one_cycle v=%b r=%b exp 0 1",
               wb_valid, in_ready);
    end
    issue(0, 0, 3'd0, 2'd0, 0, 5'd0, 32'h55, 32'h104);
    checks++;
    if (wb_valid !== 1'b1 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL dest0 v=%b w=%b exp 1 0",
               wb_valid, rf_wen);
    end
    tick;
  endtask

  task automatic test_loads;
    logic [2:0]  lt  [12];
    logic [1:0]  n   [12];
    logic [31:0] rd  [12];
    logic [31:0] exv [12];
    lt  = '{1, 2, 3, 4, 0, 5, 5, 6, 6, 5, 6, 1};
    n   = '{2, 2, 2, 0, 0, 1, 3, 1, 0, 0, 3, 1};
    rd  = '{32'h0080_0000, 32'h0080_0000,
            32'h8001_0000, 32'h1234_F00F,
            32'hDEAD_BEEF, 32'hAABB_CCDD,
            32'hAABB_CCDD, 32'hAABB_CCDD,
            32'hAABB_CCDD, 32'hAABB_CCDD,
            32'hAABB_CCDD, 32'h0000_7F00};
    exv = '{32'hFFFF_FF80, 32'h0000_0080,
            32'hFFFF_8001, 32'h0000_F00F,
            32'hDEAD_BEEF, 32'hCCDD_3344,
            32'hAABB_CCDD, 32'h11AA_BBCC,
            32'hAABB_CCDD, 32'hDD22_3344,
            32'h1122_33AA, 32'h0000_007F};
    for (int i = 0; i < 12; i++) begin
      issue(1, 1, lt[i], n[i], 32'h1122_3344,
            5'd7, 32'h0, 32'h200 + i);
      tick;
      data_ok = 1'b1;
      data_rdata = rd[i];
      tick;
      data_ok = 1'b0;
      data_rdata = 32'h0;
      #1;
      checks++;
      if (wb_valid !== 1'b1 || rf_wen !== 1'b1 ||
          rf_wdata !== exv[i]) begin
        errors++;
        $display("FAIL load%0d v=%b w=%b d=%h exp 1 1 %h",
                 i, wb_valid, rf_wen, rf_wdata, exv[i]);
      end
      tick;
    end
  endtask

  task automatic test_capture_ok;
    data_ok = 1'b1;
    data_rdata = 32'h1;
    issue(1, 1, 3'd0, 2'd0, 0, 5'd8, 0, 32'h300);
    data_ok = 1'b0;
    tick;
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL capture_ok v=%b r=%b exp 0 0",
               wb_valid, in_ready);
    end
    data_ok = 1'b1;
    data_rdata = 32'h0000_00AB;
    tick;
    data_ok = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b1 || rf_wdata !== 32'hAB) begin
      errors++;
      $display("FAIL capture_ok_ret v=%b d=%h exp 1 ab",
               wb_valid, rf_wdata);
    end
    tick;
  endtask

  task automatic test_store;
    int bad;
    bad = 0;
    issue(1, 0, 3'd0, 2'd0, 0, 5'd3, 0, 32'h400);
    for (int i = 0; i < 2; i++) begin
      if (in_ready !== 1'b0 || wb_valid !== 1'b0)
        bad++;
      tick;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL store_wait bad=%0d exp 0", bad);
    end
    data_ok = 1'b1;
    tick;
    data_ok = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b1 || rf_wen !== 1'b0 ||
        wb_pc !== 32'h400) begin
      errors++;
      $display("FAIL store v=%b w=%b pc=%h exp 1 0 400",
               wb_valid, rf_wen, wb_pc);
    end
    tick;
  endtask

  task automatic test_flush_wait;
    issue(1, 1, 3'd0, 2'd0, 0, 5'd4, 0, 32'h500);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain r=%b v=%b exp 0 0",
               in_ready, wb_valid);
    end
    tick;
    data_ok = 1'b1;
    data_rdata = 32'h9999_9999;
    tick;
    data_ok = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0 ||
        rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL drain_end r=%b v=%b w=%b exp 1 0 0",
               in_ready, wb_valid, rf_wen);
    end
    issue(1, 1, 3'd0, 2'd0, 0, 5'd4, 0, 32'h504);
    flush = 1'b1;
    data_ok = 1'b1;
    tick;
    flush = 1'b0;
    data_ok = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_ok r=%b v=%b exp 1 0",
               in_ready, wb_valid);
    end
  endtask

  task automatic test_flush_ready;
    issue(0, 0, 3'd0, 2'd0, 0, 5'd6, 32'h66, 32'h600);
    flush = 1'b1;
    in_valid = 1'b1;
    in_result = 32'h77;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready v=%b w=%b exp 0 0",
               wb_valid, rf_wen);
    end
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_nocap v=%b exp 0", wb_valid);
    end
  endtask

  task automatic test_back_to_back;
    issue(0, 0, 3'd0, 2'd0, 0, 5'd10, 32'hA, 32'h700);
    in_valid  = 1'b1;
    in_dest   = 5'd11;
    in_result = 32'hB;
    in_pc     = 32'h704;
    #1;
    checks++;
    if (wb_pc !== 32'h700 || rf_wdata !== 32'hA ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_a pc=%h d=%h r=%b exp 700 a 1",
               wb_pc, rf_wdata, in_ready);
    end
    tick;
    in_valid = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_pc !== 32'h704 ||
        rf_wdata !== 32'hB || rf_waddr !== 5'd11) begin
      errors++;
      $display("FAIL b2b_b v=%b pc=%h d=%h a=%h exp 1 704 b 0b",
               wb_valid, wb_pc, rf_wdata, rf_waddr);
    end
    tick;
  endtask

  task automatic test_async_reset;
    issue(0, 0, 3'd0, 2'd0, 0, 5'd9, 32'hCAFE, 32'h800);
    checks++;
    if (wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset v=%b exp 1", wb_valid);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || rf_wen !== 1'b0 ||
        rf_waddr !== 5'd0 || rf_wdata !== 32'h0 ||
        wb_pc !== 32'h0) begin
      errors++;
      $display("FAIL async_rst v=%b w=%b a=%h d=%h pc=%h exp zeros",
               wb_valid, rf_wen, rf_waddr, rf_wdata, wb_pc);
    end
    tick;
    resetn = 1'b1;
    issue(1, 1, 3'd0, 2'd0, 0, 5'd9, 0, 32'h804);
    resetn = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || rf_wen !== 1'b0 ||
        wb_pc !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait v=%b w=%b pc=%h r=%b exp 0 0 0 1",
               wb_valid, rf_wen, wb_pc, in_ready);
    end
    #1;
    resetn = 1'b1;
    tick;
    data_ok = 1'b1;
    data_rdata = 32'h1234_5678;
    tick;
    data_ok = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || rf_wen !== 1'b0) begin
      errors++;
      $display("FAIL stray_ok v=%b w=%b exp 0 0",
               wb_valid, rf_wen);
    end
  endtask

  initial begin
    in_valid     = 1'b0;
    in_mem_req   = 1'b0;
    in_is_load   = 1'b0;
    in_load_type = 3'd0;
    in_addr_low  = 2'd0;
    in_rt_value  = 32'h0;
    in_dest      = 5'd0;
    in_result    = 32'h0;
    in_pc        = 32'h0;
    flush        = 1'b0;
    data_ok      = 1'b0;
    data_rdata   = 32'h0;
    test_reset;
    tick;
    test_nonmem;
    test_loads;
    test_capture_ok;
    test_store;
    test_flush_wait;
    test_flush_ready;
    test_back_to_back;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32, width of in_pc/wb_pc.
REQ-002 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have in_valid  input  1  memory stage presents an instruction.
REQ-005 SHALL have in_ready  output  1  stage accepts the instruction this cycle.
REQ-006 SHALL have in_mem_req  input  1  instruction's data request was accepted by data RAM.
REQ-007 SHALL have in_is_load  input  1  instruction is a load.
REQ-008 SHALL have in_load_type  input  3  LW=0, LB=1, LBU=2, LH=3, LHU=4, LWL=5, LWR=6.
REQ-009 SHALL have in_addr_low  input  2  byte offset of load address.
REQ-010 SHALL have in_rt_value  input  32  old rt value, merge source for LWL/LWR.
REQ-011 SHALL have in_dest  input  5  destination register.
REQ-012 SHALL have in_result  input  32  ALU result for non-memory instructions.
REQ-013 SHALL have in_pc  input  PC_W  instruction PC.
REQ-014 SHALL have flush  input  1  exception squash.
REQ-015 SHALL have data_ok  input  1  data RAM response strobe (load or store).
REQ-016 SHALL have data_rdata  input  32  load return data, valid with data_ok.
REQ-017 SHALL have wb_valid, rf_wen (1), rf_waddr (5), rf_wdata (32), wb_pc (PC_W), all outputs: retirement and register-file write.

Function
REQ-018 SHALL hold one instruction; FSM states EMPTY, WAIT_DATA, READY, DRAIN.
REQ-019 in_ready SHALL be 1 in EMPTY and READY, 0 in WAIT_DATA and DRAIN.
REQ-020 Capture SHALL occur when in_valid & in_ready & !flush; next state WAIT_DATA if in_mem_req, else READY.
REQ-021 With nothing captured, EMPTY/READY SHALL go to EMPTY.
REQ-022 WAIT_DATA SHALL go to READY on data_ok, latching data_rdata; data_ok on the capture cycle SHALL not count.
REQ-023 READY SHALL last exactly one cycle: wb_valid=1, wb_pc=captured pc; rf_wen = is_load-or-non-memory & dest!=0.
REQ-024 rf_wdata SHALL be in_result for non-memory, aligned load data for loads; stores SHALL have rf_wen=0.
REQ-025 Alignment: LB/LBU byte 8*n sign/zero-extended; LH/LHU halfword at n[1] sign/zero-extended; LW rdata; n=in_addr_low.
REQ-026 LWL n=0..3: {rdata[8n+7:0], rt[23-8n:0]}, n=3 gives rdata; LWR n=0..3: {rt[31:32-8n], rdata[31:8n]}, n=0 gives rdata.
REQ-027 flush in WAIT_DATA SHALL go DRAIN; with same-cycle data_ok, SHALL go EMPTY, data discarded.
REQ-028 DRAIN SHALL go EMPTY on data_ok, no writeback; in_ready=0 throughout.
REQ-029 flush in READY SHALL force wb_valid=0, rf_wen=0 that cycle; no capture.
REQ-030 data_ok in EMPTY or READY SHALL be ignored.
REQ-031 Latency: non-memory 1 cycle capture-to-retire; memory 1 cycle after data_ok.

Reset
REQ-032 resetn low SHALL force EMPTY, wb_valid=0, rf_wen=0, rf_waddr=0, rf_wdata=0, wb_pc=0, asynchronously, including mid-WAIT_DATA/DRAIN; pending response discarded.

Structure
REQ-033 Load-type codes and FSM encoding SHALL live in shared package cpu_pkg.
REQ-034 Alignment SHALL be combinational sub-module load_align (type, offset, rdata, rt -> value).

Verification
REQ-035 Non-memory in_result=0x1234, dest=5 -> next cycle wb_valid=1, rf_wen=1, rf_wdata=0x1234.
REQ-036 LB n=2, data_ok rdata=0x00800000 two cycles later -> rf_wdata=0xFFFFFF80; LBU -> 0x00000080.
REQ-037 LWL n=1, rdata=0xAABBCCDD, rt=0x11223344 -> 0xCCDD3344; LWR n=1 -> 0x11AABBCC.
REQ-038 Store with data_ok after 3 cycles -> in_ready=0 while waiting, wb_valid=1, rf_wen=0.
REQ-039 flush in WAIT_DATA, data_ok 2 cycles later -> DRAIN, no rf write, in_ready=1 after data_ok.
REQ-040 resetn low in WAIT_DATA -> all outputs 0 immediately; later stray data_ok ignored.
